// File: rtl/fetch_if.sv
// Fetch unit handshake bundle: redirect input, instruction-memory port and decode queue head.
// master = fetch unit side, slave = memory / control-transfer / decode side.
interface fetch_if;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        ir_valid;
   logic        ir_ready;
   logic [31:0] ir;
   logic [31:0] ir_pc;

   modport master (
      input  redirect_valid, redirect_pc, imem_ack, imem_rdata, ir_ready,
      output imem_req, imem_addr, ir_valid, ir, ir_pc
   );

   modport slave (
      output redirect_valid, redirect_pc, imem_ack, imem_rdata, ir_ready,
      input  imem_req, imem_addr, ir_valid, ir, ir_pc
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: owns the PC, issues imem requests and buffers
// fetched words with their addresses in a 2-entry queue for decode.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned PC_STEP  = 4
) (
   input logic     clk,
   input logic     rst,
   fetch_if.master bus
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FETCH = 2'd1;
   localparam logic [1:0] S_FULL  = 2'd2;
   localparam logic [1:0] S_DROP  = 2'd3;

   logic [1:0]  state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] addr_q, addr_d;
   logic        req_q, req_d;
   logic        valid_q, valid_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [31:0] ir0_q, ir0_d, pc0_q, pc0_d;
   logic [31:0] ir1_q, ir1_d, pc1_q, pc1_d;

   logic        redirect, pop, push, wr_slot1;
   logic [1:0]  cnt_after_pop;

   assign redirect      = bus.redirect_valid;
   assign pop           = valid_q & bus.ir_ready;
   // An ack while a redirect is present belongs to the old stream and is dropped.
   assign push          = (state_q == S_FETCH) & bus.imem_ack & ~redirect;
   assign cnt_after_pop = cnt_q - {1'b0, pop};
   assign wr_slot1      = (cnt_after_pop != 2'd0);

   // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      addr_d  = addr_q;
      cnt_d   = cnt_q;
      ir0_d   = ir0_q;
      pc0_d   = pc0_q;
      ir1_d   = ir1_q;
      pc1_d   = pc1_q;

      if (redirect) begin
         cnt_d = 2'd0;
      end else begin
         cnt_d = cnt_after_pop + {1'b0, push};
         if (pop) begin
            ir0_d = ir1_q;
            pc0_d = pc1_q;
         end
         if (push && wr_slot1) begin
            ir1_d = bus.imem_rdata;
            pc1_d = pc_q;
         end else if (push) begin
            ir0_d = bus.imem_rdata;
            pc0_d = pc_q;
         end
      end

      if (redirect) begin
         pc_d = {bus.redirect_pc[31:2], 2'b00};
         // A request already on the bus must be held until acked, then discarded.
         if (req_q && !bus.imem_ack) begin
            state_d = S_DROP;
         end else begin
            state_d = S_FETCH;
            addr_d  = pc_d;
         end
      end else begin
         case (state_q)
            S_IDLE: begin
               state_d = S_FETCH;
               addr_d  = pc_q;
            end
            S_FETCH: begin
               if (bus.imem_ack) begin
                  pc_d    = pc_q + PC_STEP;
                  addr_d  = pc_d;
                  state_d = (cnt_d == 2'd2) ? S_FULL : S_FETCH;
               end
            end
            S_FULL: begin
               if (pop) begin
                  state_d = S_FETCH;
                  addr_d  = pc_q;
               end
            end
            default: begin
               if (bus.imem_ack) begin
                  state_d = S_FETCH;
                  addr_d  = pc_q;
               end
            end
         endcase
      end

      req_d   = (state_d == S_FETCH) || (state_d == S_DROP);
      valid_d = (cnt_d != 2'd0);
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         pc_q    <= RESET_PC;
         addr_q  <= RESET_PC;
         req_q   <= 1'b0;
         valid_q <= 1'b0;
         cnt_q   <= 2'd0;
         // NOTE: queue slots are reset too, since slot 0 drives ir/ir_pc directly and must read 0 in reset.
         ir0_q   <= '0;
         pc0_q   <= '0;
         ir1_q   <= '0;
         pc1_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         addr_q  <= addr_d;
         req_q   <= req_d;
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
         ir0_q   <= ir0_d;
         pc0_q   <= pc0_d;
         ir1_q   <= ir1_d;
         pc1_q   <= pc1_d;
      end
   end

   assign bus.imem_req  = req_q;
   assign bus.imem_addr = addr_q;
   assign bus.ir_valid  = valid_q;
   assign bus.ir        = ir0_q;
   assign bus.ir_pc     = pc0_q;

endmodule
